clock_ctrl: RTL and testbench

- Mode/sequencing controller for the stopwatch-clock counter chain (seconds, minutes, hours counters).
- Generates the 1 Hz count enable and handles run/stop.
- Handles a set-mode state machine that routes user up/down buttons as single-cycle incr/dcr pulses to exactly one counter field.
- Drives edit-field select and blink for the display.

---
 rtl/clock_ctrl.sv | 156 +++++++++++++++
 tb/tb_clock_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Stopwatch-clock mode controller: 1 Hz enable, run/stop, set-mode field editing with
// blink and inactivity timeout. Button events are synchronised and edge-detected.
module clock_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned CW        = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_run,
  output logic       sec_en,
  output logic       sec_incr,
  output logic       sec_dcr,
  output logic       min_incr,
  output logic       min_dcr,
  output logic       hr_incr,
  output logic       hr_dcr,
  output logic [1:0] edit_sel,
  output logic       blink,
  output logic       running
);

  localparam int unsigned TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;

  localparam logic [1:0]    StRun  = 2'd0;
  localparam logic [1:0]    StSec  = 2'd1;
  localparam logic [1:0]    StMin  = 2'd2;
  localparam logic [1:0]    StHour = 2'd3;

  localparam logic [CW-1:0] TickLast = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] HalfLast = CW'(TICK_DIV / 2 - 1);
  localparam logic [TW-1:0] ToLast   = TW'(TIMEOUT_S - 1);

  // Button vector order: {run, down, up, mode}
  logic [3:0]    btn_meta_q, btn_sync_q, btn_prev_q, btn_ev_q;
  logic [CW-1:0] presc_q, presc_d;
  logic [TW-1:0] to_q, to_d;
  logic [1:0]    state_q, state_d;
  logic          running_q, running_d;
  logic          blink_q, blink_d;
  // Pulse order: {hr_dcr, hr_incr, min_dcr, min_incr, sec_dcr, sec_incr, sec_en}
  logic [6:0]    pulse_q, pulse_d;

  logic mode_ev, up_ev, down_ev, run_ev;
  logic tick, half, presc_clr;

  assign mode_ev = btn_ev_q[0];
  assign up_ev   = btn_ev_q[1];
  assign down_ev = btn_ev_q[2];
  assign run_ev  = btn_ev_q[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      btn_ev_q   <= '0;
    end else begin
      btn_meta_q <= {btn_run, btn_down, btn_up, btn_mode};
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      btn_ev_q   <= btn_sync_q & ~btn_prev_q;
    end
  end

  always_comb begin
    tick      = (presc_q == TickLast);
    half      = (presc_q == HalfLast);
    state_d   = state_q;
    running_d = running_q;
    to_d      = to_q;
    presc_clr = 1'b0;
    pulse_d   = '0;

    if (state_q == StRun) begin
      to_d = '0;
      if (mode_ev) begin
        state_d = StSec;
      end else if (run_ev) begin
        running_d = ~running_q;
      end
      pulse_d[0] = tick & running_q;
    end else begin
      if (mode_ev) begin
        state_d   = (state_q == StHour) ? StRun : state_q + 2'd1;
        presc_clr = (state_q == StHour);
      end else if (tick && (to_q == ToLast)) begin
        state_d   = StRun;
        presc_clr = 1'b1;
      end

      // Simultaneous up+down cancels; mode always wins.
      if (!mode_ev && (up_ev != down_ev)) begin
        case (state_q)
          StSec:   pulse_d[2:1] = {down_ev, up_ev};
          StMin:   pulse_d[4:3] = {down_ev, up_ev};
          StHour:  pulse_d[6:5] = {down_ev, up_ev};
          default: pulse_d      = '0;
        endcase
      end

      if (mode_ev || up_ev || down_ev) begin
        to_d = '0;
      end else if (tick) begin
        to_d = to_q + 1'b1;
      end
    end

    if (state_d != state_q) begin
      to_d = '0;
    end

    if ((state_d != state_q) || (state_q == StRun)) begin
      blink_d = 1'b1;
    end else if (tick || half) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end

    presc_d = (presc_clr || tick) ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      to_q      <= '0;
      state_q   <= StRun;
      running_q <= 1'b0;
      blink_q   <= 1'b1;
      pulse_q   <= '0;
    end else begin
      presc_q   <= presc_d;
      to_q      <= to_d;
      state_q   <= state_d;
      running_q <= running_d;
      blink_q   <= blink_d;
      pulse_q   <= pulse_d;
    end
  end

  assign sec_en   = pulse_q[0];
  assign sec_incr = pulse_q[1];
  assign sec_dcr  = pulse_q[2];
  assign min_incr = pulse_q[3];
  assign min_dcr  = pulse_q[4];
  assign hr_incr  = pulse_q[5];
  assign hr_dcr   = pulse_q[6];
  assign edit_sel = state_q;
  assign blink    = blink_q;
  assign running  = running_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with TICK_DIV=10, TIMEOUT_S=3.
// Outputs are sampled on the falling edge; pulse/toggle counts come from a posedge monitor.
module tb_clock_ctrl;

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_DOWN = 4'b0100;
  localparam logic [3:0] B_RUN  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode, btn_up, btn_down, btn_run;
  logic       sec_en, sec_incr, sec_dcr, min_incr, min_dcr, hr_incr, hr_dcr;
  logic [1:0] edit_sel;
  logic       blink, running;
  logic [6:0] pv;

  int errors = 0;
  int checks = 0;
  int n;

  int unsigned hi   [7];
  int unsigned rise [7];
  int unsigned hi0  [7];
  int unsigned rise0[7];
  int unsigned tog  = 0;
  int unsigned tog0 = 0;
  logic [6:0]  pv_prev = '0;
  logic        blink_prev = 1'b1;

  clock_ctrl #(
    .TICK_DIV (10),
    .TIMEOUT_S(3),
    .CW       (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_run (btn_run),
    .sec_en  (sec_en),
    .sec_incr(sec_incr),
    .sec_dcr (sec_dcr),
    .min_incr(min_incr),
    .min_dcr (min_dcr),
    .hr_incr (hr_incr),
    .hr_dcr  (hr_dcr),
    .edit_sel(edit_sel),
    .blink   (blink),
    .running (running)
  );

  always #5 clk = ~clk;

  assign pv = {hr_dcr, hr_incr, min_dcr, min_incr, sec_dcr, sec_incr, sec_en};

  initial begin
    for (int i = 0; i < 7; i++) begin
      hi[i]   = 0;
      rise[i] = 0;
    end
  end

  // Counts the values held during the cycle that ends at this edge.
  always @(posedge clk) begin
    for (int i = 0; i < 7; i++) begin
      hi[i]   <= hi[i] + 32'(pv[i]);
      rise[i] <= rise[i] + 32'(pv[i] & ~pv_prev[i]);
    end
    tog        <= tog + 32'(blink != blink_prev);
    pv_prev    <= pv;
    blink_prev <= blink;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 7; i++) begin
      hi0[i]   = hi[i];
      rise0[i] = rise[i];
    end
    tog0 = tog;
  endtask

  task automatic chk_one(input string tag, input int idx, input int cnt);
    check($sformatf("%s_rise%0d", tag, idx), rise[idx] - rise0[idx], cnt);
    check($sformatf("%s_hi%0d", tag, idx), hi[idx] - hi0[idx], cnt);
  endtask

  // idx < 0 expects no pulse on any output.
  task automatic chk_pulses(input string tag, input int idx, input int cnt);
    for (int i = 0; i < 7; i++) begin
      chk_one(tag, i, (i == idx) ? cnt : 0);
    end
  endtask

  task automatic press(input logic [3:0] m);
    {btn_run, btn_down, btn_up, btn_mode} = m;
    repeat (3) @(negedge clk);
    {btn_run, btn_down, btn_up, btn_mode} = 4'b0000;
  endtask

  task automatic wait_sel(input logic [1:0] v, output int cnt);
    cnt = 0;
    while (edit_sel !== v && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic wait_en(output int cnt);
    cnt = 0;
    while (sec_en !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {btn_run, btn_down, btn_up, btn_mode} = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_running", running, 0);
    check("rst_sel", edit_sel, 0);
    check("rst_blink", blink, 1);
    check("rst_pulses", pv, 0);
    rst_n = 1'b1;
    snap();
    repeat (15) @(negedge clk);
    chk_one("stopped", 0, 0);

    // Start, then measure enable period and width
    press(B_RUN);
    @(negedge clk);
    check("run_on", running, 1);
    wait_en(n);
    check("en_found", sec_en, 1);
    @(negedge clk);
    check("en_width", sec_en, 0);
    wait_en(n);
    check("en_period", n + 1, 10);

    // Stop: no further enables
    press(B_RUN);
    @(negedge clk);
    check("run_off", running, 0);
    @(negedge clk);
    snap();
    repeat (25) @(negedge clk);
    chk_one("stop_en", 0, 0);
    press(B_RUN);
    @(negedge clk);
    check("run_on2", running, 1);

    // SET_SEC: blink rate, no enable, three increments
    press(B_MODE);
    wait_sel(2'd1, n);
    check("sel_sec", edit_sel, 1);
    snap();
    repeat (10) @(negedge clk);
    check("blink_tog", tog - tog0, 2);
    chk_one("set_no_en", 0, 0);
    check("set_running", running, 1);
    snap();
    for (int k = 0; k < 3; k++) begin
      press(B_UP);
      repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk_pulses("up3", 1, 3);
    check("still_sec", edit_sel, 1);

    // SET_MIN: down, then up+down together
    press(B_MODE);
    wait_sel(2'd2, n);
    check("sel_min", edit_sel, 2);
    snap();
    press(B_DOWN);
    repeat (4) @(negedge clk);
    chk_pulses("down_min", 4, 1);
    snap();
    press(B_UP | B_DOWN);
    repeat (4) @(negedge clk);
    chk_pulses("updown", -1, 0);
    check("still_min", edit_sel, 2);

    // SET_HOUR -> RUN: first enable ten cycles after leaving
    press(B_MODE);
    wait_sel(2'd3, n);
    check("sel_hour", edit_sel, 3);
    press(B_MODE);
    wait_sel(2'd0, n);
    check("sel_run", edit_sel, 0);
    wait_en(n);
    check("first_en", n, 10);

    // Timeout from SET_SEC with prescaler phase known (0 at this edge)
    press(B_MODE);
    wait_sel(2'd1, n);
    check("to_enter", n, 1);
    wait_sel(2'd0, n);
    check("to_return", n, 26);
    wait_en(n);
    check("to_first_en", n, 10);

    // Up press landing on tick 2 restarts the timeout
    press(B_MODE);
    wait_sel(2'd1, n);
    repeat (12) @(negedge clk);
    snap();
    press(B_UP);
    wait_sel(2'd0, n);
    check("to_delayed", n, 31);
    chk_pulses("to_up", 1, 1);

    // Mode with up in SET_SEC: mode wins
    press(B_MODE);
    wait_sel(2'd1, n);
    snap();
    press(B_MODE | B_UP);
    wait_sel(2'd2, n);
    repeat (3) @(negedge clk);
    check("modeup_sel", edit_sel, 2);
    chk_pulses("modeup", -1, 0);

    // Held up button: one pulse, then timeout back to RUN
    snap();
    btn_up = 1'b1;
    repeat (50) @(negedge clk);
    btn_up = 1'b0;
    repeat (4) @(negedge clk);
    chk_one("held", 3, 1);
    check("held_timeout", edit_sel, 0);

    // Reset with an hr_incr pulse on the outputs
    press(B_MODE);
    wait_sel(2'd1, n);
    press(B_MODE);
    wait_sel(2'd2, n);
    press(B_MODE);
    wait_sel(2'd3, n);
    check("sel_hour2", edit_sel, 3);
    press(B_UP);
    @(negedge clk);
    check("hr_pulse", hr_incr, 1);
    check("pre_rst_run", running, 1);
    rst_n = 1'b0;
    #1;
    check("arst_hr", hr_incr, 0);
    check("arst_sel", edit_sel, 0);
    check("arst_run", running, 0);
    check("arst_blink", blink, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap();
    repeat (20) @(negedge clk);
    chk_pulses("post_rst", -1, 0);
    check("post_run", running, 0);
    check("post_blink", blink, 1);
    check("post_sel", edit_sel, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
